regfile_sb: RTL

Register file with per-register reservation scoreboard: the responder for the instruction-decode stage's register-file port. It serves two combinational reads (rd, rs) with reservation status, records a reservation when decode issues an instruction that writes back, and clears it when the writeback stage returns the result. A same-cycle writeback is forwarded to the read ports so decode sees the new value and the released reservation without a bubble.

---
 rtl/regfile_sb_pkg.sv | 11 +
 rtl/regfile_fwd.sv | 24 ++
 rtl/regfile_sb.sv | 84 ++++++++
 3 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared widths and types for the decode-side register file
// with writeback reservation scoreboard.
package regfile_sb_pkg;
  localparam int WORD = 16;
  localparam int W_RD = 3;
  localparam int W_RS = W_RD;
  localparam int NREG = 1 << W_RD;

  typedef logic [WORD-1:0] word_t;
  typedef logic [W_RD-1:0] name_t;
endpackage

// File: rtl/regfile_fwd.sv
// One read port: array mux, writeback bypass and
// reservation masking when the pending result lands now.
module regfile_fwd
  import regfile_sb_pkg::*;
#(
  parameter int WORD = regfile_sb_pkg::WORD,
  parameter int W_RD = regfile_sb_pkg::W_RD,
  parameter int NREG = regfile_sb_pkg::NREG
) (
  input  logic [NREG-1:0][WORD-1:0] regs,
  input  logic [NREG-1:0]           res,
  input  logic [W_RD-1:0]           name,
  input  logic                      wb_i,
  input  logic [W_RD-1:0]           wb_name_i,
  input  logic [WORD-1:0]           wb_data_i,
  output logic [WORD-1:0]           data,
  output logic                      reserved
);
  logic hit;

  assign hit      = wb_i & (wb_name_i == name);
  assign data     = hit ? wb_data_i : regs[name];
  assign reserved = res[name] & ~hit;
endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register reservation bits and a
// sticky protocol error flag; reads are forwarded from writeback.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WORD = regfile_sb_pkg::WORD,
  parameter int W_RD = regfile_sb_pkg::W_RD,
  parameter int NREG = regfile_sb_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_i,
  input  logic            rd_reserve_i,
  input  logic [W_RD-1:0] rd_name_i,
  input  logic [W_RD-1:0] rs_name_i,
  output logic [WORD-1:0] rd_data_o,
  output logic [WORD-1:0] rs_data_o,
  output logic            rd_reserved_o,
  output logic            rs_reserved_o,
  input  logic            wb_i,
  input  logic [W_RD-1:0] wb_name_i,
  input  logic [WORD-1:0] wb_data_i,
  output logic            err_o
);
  logic [NREG-1:0][WORD-1:0] regs;
  logic [NREG-1:0]           res;
  logic                      err;
  logic                      resv;
  logic                      wb_hit_rd;
  logic                      err_set;

  assign resv      = issue_i & rd_reserve_i;
  assign wb_hit_rd = wb_i & (wb_name_i == rd_name_i);

  // Reserving a busy register is legal only if it is released now.
  assign err_set = (wb_i & ~res[wb_name_i])
                 | (resv & res[rd_name_i] & ~wb_hit_rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '0;
      res  <= '0;
      err  <= 1'b0;
    end else begin
      if (wb_i) begin
        regs[wb_name_i] <= wb_data_i;
        res[wb_name_i]  <= 1'b0;
      end
      // New reservation outlives the one retiring this cycle.
      if (resv)
        res[rd_name_i] <= 1'b1;
      if (err_set)
        err <= 1'b1;
    end
  end

  assign err_o = err;

  regfile_fwd #(
    .WORD(WORD), .W_RD(W_RD), .NREG(NREG)
  ) u_fwd_rd (
    .regs      (regs),
    .res       (res),
    .name      (rd_name_i),
    .wb_i      (wb_i),
    .wb_name_i (wb_name_i),
    .wb_data_i (wb_data_i),
    .data      (rd_data_o),
    .reserved  (rd_reserved_o)
  );

  regfile_fwd #(
    .WORD(WORD), .W_RD(W_RD), .NREG(NREG)
  ) u_fwd_rs (
    .regs      (regs),
    .res       (res),
    .name      (rs_name_i),
    .wb_i      (wb_i),
    .wb_name_i (wb_name_i),
    .wb_data_i (wb_data_i),
    .data      (rs_data_o),
    .reserved  (rs_reserved_o)
  );
endmodule
